// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Control bundle between the multicycle MIPS control unit and
//                its datapath. The control unit is the master: it receives
//                the IR opcode and the ALU zero flag and drives every
//                datapath control.
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic [3:0] state;
    logic       pcen;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    // Control unit side
    modport master (
        input  opcode, zero,
        output state, pcen, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource
    );

    // Datapath side
    modport slave (
        output opcode, zero,
        input  state, pcen, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore-style control FSM for a multicycle MIPS datapath.
//                Sequences fetch / decode / execute / memory / write-back
//                and drives all datapath controls from the state register.
//                Optional macro MC_ADDI_EN adds the addi path
//                (ADDIEX -> ADDIWB); without it opcode 001000 is illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control (
    input  wire logic            clk,
    input  wire logic            clr,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
`ifdef MC_ADDI_EN
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
`else
        JUMP   = 4'd9
`endif
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`endif

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;

    // State register; clr abandons any partial instruction and restarts fetch
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; opcode matters only in DECODE and MEMADR
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (bus.opcode)
                    c_OP_LW,
                    c_OP_SW:    w_next = MEMADR;
                    c_OP_RTYPE: w_next = EXEC;
                    c_OP_BEQ:   w_next = BRANCH;
                    c_OP_J:     w_next = JUMP;
`ifdef MC_ADDI_EN
                    c_OP_ADDI:  w_next = ADDIEX;
`endif
                    default:    w_next = FETCH;   // illegal opcode is a no-op
                endcase
            end
            MEMADR: w_next = (bus.opcode == c_OP_SW) ? MEMWR : MEMRD;
            MEMRD:  w_next = MEMWB;
            EXEC:   w_next = RCOMP;
`ifdef MC_ADDI_EN
            ADDIEX: w_next = ADDIWB;
`endif
            default: w_next = FETCH;              // MEMWB, MEMWR, RCOMP, BRANCH, JUMP, ADDIWB
        endcase
    end

    // Moore output decode from the state register alone
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            DECODE: w_alu_src_b = 2'b11;
            MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            RCOMP: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
            end
            JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
            end
`ifdef MC_ADDI_EN
            ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ADDIWB: w_reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    // Write strobes are suppressed while clr is high so nothing is
    // committed from a state that is about to be discarded.
    assign bus.state       = r_state;
    assign bus.PCWrite     = w_pc_write      & ~clr;
    assign bus.PCWriteCond = w_pc_write_cond & ~clr;
    assign bus.IRWrite     = w_ir_write      & ~clr;
    assign bus.MemWrite    = w_mem_write     & ~clr;
    assign bus.RegWrite    = w_reg_write     & ~clr;
    assign bus.pcen        = (w_pc_write | (w_pc_write_cond & bus.zero)) & ~clr;
    assign bus.IorD        = w_iord;
    assign bus.MemRead     = w_mem_read;
    assign bus.MemtoReg    = w_mem_to_reg;
    assign bus.RegDst      = w_reg_dst;
    assign bus.ALUSrcA     = w_alu_src_a;
    assign bus.ALUSrcB     = w_alu_src_b;
    assign bus.ALUOp       = w_alu_op;
    assign bus.PCSource    = w_pc_source;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. A reference
//                model gives the state trace per opcode and the control word
//                per state; inputs outside the sampled states are randomized.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    logic clk;
    logic clr;
    int   checks;
    int   errors;
    int   rw_seen;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write strobes (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite)
    localparam logic [15:0] c_WRITE_MASK = 16'hCC80;

    // Expected control word for a state code, bit order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
    function automatic logic [15:0] ctrl_word(input int st);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mrd = 1; irw = 1; pcw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    endfunction

    // State trace of one instruction, starting with FETCH
    task automatic inst_trace(input logic [5:0] op, output int seq[6], output int n);
        seq = '{0, 1, 0, 0, 0, 0};
        n = 2;
        case (op)
            6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; n = 5; end
            6'b101011: begin seq[2] = 2; seq[3] = 5; n = 4; end
            6'b000000: begin seq[2] = 6; seq[3] = 7; n = 4; end
            6'b000100: begin seq[2] = 8; n = 3; end
            6'b000010: begin seq[2] = 9; n = 3; end
`ifdef MC_ADDI_EN
            6'b001000: begin seq[2] = 10; seq[3] = 11; n = 4; end
`endif
            default: n = 2;
        endcase
    endtask

    // One clock cycle: drive inputs on the falling edge, then check outputs
    task automatic step(input int exp_st, input logic [5:0] op_in,
                        input logic z_in, input logic clr_in);
        logic [15:0] exp_w;
        logic [15:0] got_w;
        logic        exp_pcen;
        @(negedge clk);
        bus.opcode = op_in;
        bus.zero   = z_in;
        clr        = clr_in;
        #1;
        exp_w = ctrl_word(exp_st);
        if (clr_in) exp_w = exp_w & ~c_WRITE_MASK;
        exp_pcen = !clr_in && (exp_w[15] || (exp_w[14] && z_in));
        got_w = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.PCSource};
        if (bus.RegWrite === 1'b1) rw_seen++;
        checks++;
        if (bus.state !== 4'(exp_st)) begin
            errors++;
            $display("FAIL state: got %0d expected %0d at %0t", bus.state, exp_st, $time);
        end
        checks++;
        if (got_w !== exp_w) begin
            errors++;
            $display("FAIL ctrl(st=%0d): got %h expected %h at %0t", exp_st, got_w, exp_w, $time);
        end
        checks++;
        if (bus.pcen !== exp_pcen) begin
            errors++;
            $display("FAIL pcen(st=%0d): got %b expected %b at %0t", exp_st, bus.pcen, exp_pcen, $time);
        end
    endtask

    // Run a full instruction; zmode 0/1 forces zero in BRANCH, 2 = random
    task automatic run_instr(input logic [5:0] op, input int zmode);
        int seq[6];
        int n;
        logic [5:0] opd;
        logic       z;
        inst_trace(op, seq, n);
        for (int i = 0; i < n; i++) begin
            opd = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
            z   = (seq[i] == 8 && zmode < 2) ? 1'(zmode) : 1'($urandom);
            step(seq[i], opd, z, 1'b0);
        end
    endtask

    task automatic test_reset;
        step(0, 6'($urandom), 1'($urandom), 1'b1);
        step(0, 6'($urandom), 1'($urandom), 1'b1);
        step(0, 6'($urandom), 1'($urandom), 1'b0);  // release: pcen live
        step(1, 6'b000000,    1'($urandom), 1'b0);
        step(6, 6'($urandom), 1'($urandom), 1'b0);
        step(7, 6'($urandom), 1'($urandom), 1'b1);  // clr in RCOMP
        step(0, 6'($urandom), 1'($urandom), 1'b1);
        step(0, 6'($urandom), 1'($urandom), 1'b0);
        step(1, 6'b111111,    1'($urandom), 1'b0);
    endtask

    task automatic test_lw;     run_instr(6'b100011, 2); endtask
    task automatic test_sw;     run_instr(6'b101011, 2); endtask
    task automatic test_rtype;  run_instr(6'b000000, 2); endtask
    task automatic test_jump;   run_instr(6'b000010, 2); endtask

    task automatic test_beq;
        run_instr(6'b000100, 1);
        run_instr(6'b000100, 0);
    endtask

    task automatic test_addi_and_illegal;
        run_instr(6'b001000, 2);
        run_instr(6'b111111, 2);
    endtask

    task automatic test_clr_mid_lw;
        rw_seen = 0;
        step(0, 6'($urandom), 1'($urandom), 1'b0);
        step(1, 6'b100011,    1'($urandom), 1'b0);
        step(2, 6'b100011,    1'($urandom), 1'b0);
        step(3, 6'b100011,    1'($urandom), 1'b1);
        step(0, 6'b100011,    1'($urandom), 1'b0);
        step(1, 6'b111111,    1'($urandom), 1'b0);
        checks++;
        if (rw_seen != 0) begin
            errors++;
            $display("FAIL abandoned_lw_regwrite: got %0d cycles expected 0", rw_seen);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[8];
        logic [5:0] op;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000010, 6'b001000, 6'b111111, 6'b000000};
        for (int k = 0; k < 80; k++) begin
            op = ops[$urandom_range(0, 7)];
            if (k % 8 == 7) op = 6'($urandom);
            run_instr(op, 2);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rw_seen    = 0;
        clr        = 1'b1;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        test_reset;
        test_lw;
        test_sw;
        test_rtype;
        test_beq;
        test_jump;
        test_addi_and_illegal;
        test_clr_mid_lw;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
